// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file read side: index width, dump FSM
// state encoding and the bytes-per-register derivation.
package reg_dump_reader_pkg;

   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   function automatic int nb_of(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/reg_dump_reader_byte_lane_sel.sv
// Combinational byte-lane picker: returns byte sel_i of a DATA_W-bit word,
// lane 0 being the least significant byte.
module byte_lane_sel
   import reg_dump_reader_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 1
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [7:0]        byte_o
);

   localparam int NB = nb_of(DATA_W);

   logic [NB-1:0][7:0] lanes_s;

   // Reshape the word into byte lanes and pick one
   always_comb begin
      lanes_s = word_i;
      byte_o  = lanes_s[sel_i];
   end

endmodule

// File: rtl/reg_dump_reader.sv
// Snapshots all register outputs on Start and streams the selected index
// range (wrapping mod 16) as bytes, MSB first, over a valid/ready handshake.
module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int NREGS  = 16,
   parameter int DATA_W = 16
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NREGS*DATA_W-1:0] RegData,
   input  logic                    Start,
   input  logic [IDX_W-1:0]        FirstIdx,
   input  logic [IDX_W-1:0]        LastIdx,
   output logic [7:0]              TxData,
   output logic                    TxValid,
   input  logic                    TxReady,
   output logic                    Busy,
   output logic                    Done
);

   localparam int NB = nb_of(DATA_W);
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

   state_e                       state_q, state_d;
   logic [NREGS-1:0][DATA_W-1:0] snap_q, snap_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [IDX_W-1:0]             stop_q, stop_d;
   logic [BW-1:0]                b_q, b_d;
   logic [7:0]                   tx_data_q, tx_data_d;
   logic                         tx_valid_q, busy_q, done_q;
   logic [DATA_W-1:0]            word_s;
   logic [7:0]                   lane_byte_s;

   // Next-state logic: capture on accepted Start, walk bytes then indices
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      b_d     = b_q;
      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (Start) begin
               snap_d  = RegData;
               idx_d   = FirstIdx;
               stop_d  = LastIdx;
               b_d     = B_LAST;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (TxReady) begin
               if (b_q != '0) begin
                  b_d = b_q - BW'(1);
               end else if (idx_q == stop_q) begin
                  state_d = ST_FIN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  b_d   = B_LAST;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The outgoing byte is looked up from next-state values so TxData can be a flop
   assign word_s = snap_d[idx_d];

   byte_lane_sel #(
      .DATA_W (DATA_W),
      .SEL_W  (BW)
   ) u_lane (
      .word_i (word_s),
      .sel_i  (b_d),
      .byte_o (lane_byte_s)
   );

   // Load a new byte only while streaming; otherwise hold the last one
   always_comb begin
      if (state_d == ST_SEND) begin
         tx_data_d = lane_byte_s;
      end else begin
         tx_data_d = tx_data_q;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         idx_q      <= '0;
         stop_q     <= '0;
         b_q        <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         b_q        <= b_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= (state_d == ST_SEND);
         busy_q     <= (state_d == ST_SEND);
         done_q     <= (state_d == ST_FIN);
      end
   end

   assign TxData  = tx_data_q;
   assign TxValid = tx_valid_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader against a queue-based
// model of the expected byte stream.
module tb_reg_dump_reader;

   logic         clk;
   logic         clr;
   logic [255:0] reg_data;
   logic         Start;
   logic [3:0]   FirstIdx;
   logic [3:0]   LastIdx;
   logic [7:0]   TxData;
   logic         TxValid;
   logic         TxReady;
   logic         Busy;
   logic         Done;

   int           vectors    = 0;
   int           miscompares = 0;
   int           ready_pct  = 100;
   logic [7:0]   exp_q[$];

   reg_dump_reader #(.NREGS(16), .DATA_W(16)) dut (
      .clk      (clk),
      .clr      (clr),
      .RegData  (reg_data),
      .Start    (Start),
      .FirstIdx (FirstIdx),
      .LastIdx  (LastIdx),
      .TxData   (TxData),
      .TxValid  (TxValid),
      .TxReady  (TxReady),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected stream: registers first..last (wrapping), high byte first.
   function automatic void model_load(input logic [255:0] snap, input int first, input int last);
      int n;
      logic [15:0] w;
      exp_q.delete();
      n = ((last - first + 16) % 16) + 1;
      for (int k = 0; k < n; k++) begin
         w = snap[16*((first + k) % 16) +: 16];
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
      end
   endfunction

   task automatic randomize_regs();
      for (int i = 0; i < 16; i++) reg_data[16*i +: 16] = 16'($urandom_range(0, 65535));
   endtask

   // Called just after a rising edge; returns at the following falling edge.
   task automatic start_dump(input int first, input int last, input bit expect_fin);
      Start    = 1'b1;
      FirstIdx = 4'(first);
      LastIdx  = 4'(last);
      model_load(reg_data, first, last);
      if (expect_fin) begin
         @(negedge clk);
         check_val("fin_done", Done, 1'b1);
         check_val("fin_valid", TxValid, 1'b0);
      end
      @(posedge clk); #2;
      Start   = 1'b0;
      TxReady = ($urandom_range(1, 100) <= ready_pct);
      @(negedge clk);
      check_val("start_busy", Busy, 1'b1);
      check_val("start_valid", TxValid, 1'b1);
      if (expect_fin) check_val("done_len", Done, 1'b0);
   endtask

   // Starts at a falling edge; returns just after the edge of the last transfer.
   task automatic stream(input bit mutate, input bit midstart, input int stop_after);
      int         xfers = 0;
      bit         stalled = 1'b0;
      bit         last = 1'b0;
      logic [7:0] held = 8'h00;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         check_val("valid", TxValid, 1'b1);
         if (stalled) check_val("hold", TxData, held);
         if (TxReady) begin
            check_val("byte", TxData, exp_q.pop_front());
            xfers++;
            stalled = 1'b0;
            if (exp_q.size() == 0 || xfers == stop_after) last = 1'b1;
         end else begin
            stalled = 1'b1;
            held    = TxData;
         end
         @(posedge clk); #2;
         Start = 1'b0;
         if (last) return;
         TxReady = ($urandom_range(1, 100) <= ready_pct);
         if (mutate) randomize_regs();
         if (midstart && cyc == 2) begin
            Start    = 1'b1;
            FirstIdx = 4'($urandom_range(0, 15));
            LastIdx  = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
      end
      check_val("timeout", exp_q.size(), 0);
   endtask

   task automatic finish_check();
      @(negedge clk);
      check_val("done", Done, 1'b1);
      check_val("done_busy", Busy, 1'b0);
      check_val("done_valid", TxValid, 1'b0);
      @(posedge clk); #2;
      @(negedge clk);
      check_val("done_pulse", Done, 1'b0);
      @(posedge clk); #2;
   endtask

   initial begin
      clr      = 1'b1;
      Start    = 1'b0;
      FirstIdx = 4'd0;
      LastIdx  = 4'd0;
      TxReady  = 1'b0;
      reg_data = '0;
      repeat (2) @(posedge clk);
      #2 clr = 1'b0;

      // Mid-cycle reset with the sink ready, then a quiet idle period.
      TxReady = 1'b1;
      @(posedge clk); #3;
      clr = 1'b1;
      #1;
      check_val("rst_valid", TxValid, 1'b0);
      check_val("rst_busy", Busy, 1'b0);
      check_val("rst_done", Done, 1'b0);
      check_val("rst_data", TxData, 8'h00);
      @(posedge clk); #2;
      clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("idle_valid", TxValid, 1'b0);
         check_val("idle_busy", Busy, 1'b0);
      end
      @(posedge clk); #2;

      // Full dump of a known pattern.
      for (int i = 0; i < 16; i++) reg_data[16*i +: 16] = 16'hA000 + 16'(i);
      ready_pct = 100;
      start_dump(0, 15, 1'b0);
      stream(1'b0, 1'b0, 0);
      finish_check();

      // Wrap-around and single register.
      start_dump(14, 1, 1'b0);
      stream(1'b0, 1'b0, 0);
      finish_check();
      start_dump(5, 5, 1'b0);
      stream(1'b0, 1'b0, 0);
      finish_check();

      // Random backpressure with RegData churning after the snapshot.
      ready_pct = 50;
      for (int t = 0; t < 6; t++) begin
         randomize_regs();
         start_dump($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
         stream(1'b1, 1'b0, 0);
         finish_check();
      end

      // Start while busy is ignored; Start in FIN chains a second dump.
      ready_pct = 70;
      randomize_regs();
      start_dump(3, 9, 1'b0);
      stream(1'b1, 1'b1, 0);
      randomize_regs();
      start_dump($urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
      stream(1'b0, 1'b0, 0);
      finish_check();

      // Reset in the middle of a dump, then a clean full dump.
      ready_pct = 100;
      randomize_regs();
      start_dump(0, 15, 1'b0);
      stream(1'b0, 1'b0, 3);
      clr = 1'b1;
      #1;
      check_val("abort_valid", TxValid, 1'b0);
      check_val("abort_busy", Busy, 1'b0);
      @(posedge clk); #2;
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("abort_done", Done, 1'b0);
         check_val("abort_idle", TxValid, 1'b0);
      end
      @(posedge clk); #2;
      randomize_regs();
      start_dump(0, 15, 1'b0);
      stream(1'b0, 1'b0, 0);
      finish_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
